dff_rs_bist: RTL and testbench



---
 rtl/dff_rs_bist_pkg.sv | 44 ++++
 rtl/dff_rs_bist_lfsr8.sv | 24 ++
 rtl/dff_rs_bist.sv | 180 ++++++++++++++++++
 tb/tb_dff_rs_bist.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_rs_bist_pkg.sv
// Shared types and constants for the set/reset flip-flop self-test controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dff_rs_bist_pkg;

   // Test sequence phases, in the order they are visited.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RST   = 3'd1,
      ST_SET   = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
   // Bits 7,5,4,3 feed back into bit 0 on each left shift.
   localparam int                LFSR_W     = 8;
   localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8;

   // An all-zero state would lock the LFSR, so a zero seed is replaced.
   localparam logic [LFSR_W-1:0] SEED_SUBST = 8'h01;

   // Bit shifted into position 0 on the next step.
   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] cur);
      return ^(cur & LFSR_TAPS);
   endfunction

   // One LFSR step.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], lfsr_fb(cur)};
   endfunction

   // Seed actually loaded into the LFSR.
   function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
      return (s == '0) ? SEED_SUBST : s;
   endfunction

   // Phases in which a stimulus vector is driven and the LFSR advances.
   function automatic logic is_stim(input state_t s);
      return (s == ST_RST) || (s == ST_SET) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/dff_rs_bist_lfsr8.sv
// Pseudo-random D source: 8-bit Fibonacci LFSR with synchronous load.
// Latency: new value one edge after load/en.
// Backpressure: none; en simply holds the state when low.
module lfsr8
   import dff_rs_bist_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   // Reset and load both restart the sequence from the seed; otherwise step when enabled.
   always_ff @(posedge clk) begin
      if (!reset_n || load) begin
         q <= seed;
      end else if (en) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/dff_rs_bist.sv
// Built-in self-test for a synchronous set/reset D flip-flop: drives stimulus, checks q against a golden model.
// Latency: done rises 2*PHASE_LEN+RUN_LEN+1 edges after the edge that samples start.
// Backpressure: start is ignored while busy; results hold in DONE until the next start or reset.
module dff_rs_bist
   import dff_rs_bist_pkg::*;
#(
   parameter int          PHASE_LEN = 4,
   parameter int          RUN_LEN   = 32,
   parameter logic [7:0]  LFSR_SEED = 8'hA5,
   parameter int          ERR_W     = 8
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             dut_d,
   output logic             dut_set_n,
   output logic             dut_reset_n,
   input  logic             dut_q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [7:0] SEED    = seed_fix(LFSR_SEED);
   localparam int         MAX_LEN = (PHASE_LEN > RUN_LEN) ? PHASE_LEN : RUN_LEN;
   localparam int         CNT_W   = $clog2(MAX_LEN + 1);

   localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_LEN - 1);
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_LEN - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             start_ok;

   logic [7:0]       lfsr_q;
   logic             lfsr_en;

   logic             d_nxt;
   logic             set_n_nxt;
   logic             reset_n_nxt;

   logic             exp_q;
   logic             check_en;
   logic             mismatch;
   logic [ERR_W-1:0] err_nxt;

   lfsr8 u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (start_ok),
      .en      (lfsr_en),
      .seed    (SEED),
      .q       (lfsr_q)
   );

   // The LFSR advances once for every cycle spent in a stimulus phase.
   assign lfsr_en = is_stim(state);

   // Next-state logic: walk the phases, counting each one down to its last cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      start_ok  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               start_ok  = 1'b1;
               state_nxt = ST_RST;
               cnt_nxt   = '0;
            end
         end
         ST_RST: begin
            if (cnt == PHASE_LAST) begin
               state_nxt = ST_SET;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_SET: begin
            if (cnt == PHASE_LAST) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt == RUN_LAST) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_DRAIN: begin
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Vector for the phase being entered. D is the LFSR bit that will be current after this edge:
   // the seed on the start edge, otherwise the bit the LFSR shifts in.
   always_comb begin
      d_nxt       = 1'b0;
      set_n_nxt   = 1'b1;
      reset_n_nxt = 1'b0;
      if (is_stim(state_nxt)) begin
         d_nxt = start_ok ? SEED[0] : lfsr_fb(lfsr_q);
      end
      if ((state_nxt == ST_RST) || (state_nxt == ST_SET)) begin
         set_n_nxt = 1'b0;
      end
      if ((state_nxt == ST_SET) || (state_nxt == ST_RUN)) begin
         reset_n_nxt = 1'b1;
      end
   end

   // Error accumulation: cleared by start, saturating at all-ones.
   always_comb begin
      mismatch = check_en && (dut_q != exp_q);
      err_nxt  = err_count;
      if (start_ok) begin
         err_nxt = '0;
      end else if (mismatch && (err_count != '1)) begin
         err_nxt = err_count + 1'b1;
      end
   end

   // Sequencer state, registered stimulus and status outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         dut_d       <= 1'b0;
         dut_set_n   <= 1'b1;
         dut_reset_n <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= '0;
         check_en    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         dut_d       <= d_nxt;
         dut_set_n   <= set_n_nxt;
         dut_reset_n <= reset_n_nxt;
         busy        <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
         done        <= (state_nxt == ST_DONE);
         pass        <= (state_nxt == ST_DONE) && (err_nxt == '0);
         err_count   <= err_nxt;
         // The flip-flop answers one edge after each vector, so comparing starts one edge late
         // and covers exactly one cycle per stimulus vector.
         check_en    <= is_stim(state);
      end
   end

   // Golden flip-flop: same one-edge latency and reset-over-set precedence as the cell under test.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         exp_q <= 1'b0;
      end else if (!dut_reset_n) begin
         exp_q <= 1'b0;
      end else if (!dut_set_n) begin
         exp_q <= 1'b1;
      end else begin
         exp_q <= dut_d;
      end
   end

endmodule

// File: tb/tb_dff_rs_bist.sv
module tb_dff_rs_bist;

   // Instance 0: default parameters. Instance 1: short phases, 2-bit counter, zero seed.
   localparam int         P0 = 4;
   localparam int         R0 = 32;
   localparam logic [7:0] SEED0 = 8'hA5;
   localparam int         P1 = 2;
   localparam int         R1 = 6;
   localparam logic [7:0] SEED1 = 8'h00;
   localparam int         WD_MAX = 120;

   typedef struct { logic d; logic sn; logic rn; } vec_t;
   typedef struct { int err; bit pass; int blen; } res_t;
   typedef struct { int at; int inst; bit busy; bit done; bit pass; int err; bit rn; } snap_t;

   logic       clk = 1'b0;
   logic       rst_n [2];
   logic       start [2];
   logic       dd    [2];
   logic       dsn   [2];
   logic       drn   [2];
   logic       dq    [2];
   logic       busy  [2];
   logic       done  [2];
   logic       pass  [2];
   logic [7:0] err0;
   logic [1:0] err1;

   // Fault modes of the flip-flop model: 0 correct, 1 set dominates reset, 2 q stuck at 0, 3 q inverted.
   int   fault [2];
   logic ffq   [2];

   vec_t  vec_q [2][$];
   res_t  res_q [2][$];
   snap_t snap_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int busy_len [2];
   int wd       [2];
   bit done_prev[2];

   always #5 clk = ~clk;

   dff_rs_bist #(.PHASE_LEN(P0), .RUN_LEN(R0), .LFSR_SEED(SEED0), .ERR_W(8)) u_dut0 (
      .clk(clk), .reset_n(rst_n[0]), .start(start[0]),
      .dut_d(dd[0]), .dut_set_n(dsn[0]), .dut_reset_n(drn[0]), .dut_q(dq[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err0)
   );

   dff_rs_bist #(.PHASE_LEN(P1), .RUN_LEN(R1), .LFSR_SEED(SEED1), .ERR_W(2)) u_dut1 (
      .clk(clk), .reset_n(rst_n[1]), .start(start[1]),
      .dut_d(dd[1]), .dut_set_n(dsn[1]), .dut_reset_n(drn[1]), .dut_q(dq[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err1)
   );

   // Flip-flop cells under test, with selectable faults.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (fault[i] == 1)
            ffq[i] <= !dsn[i] ? 1'b1 : (!drn[i] ? 1'b0 : dd[i]);
         else
            ffq[i] <= !drn[i] ? 1'b0 : (!dsn[i] ? 1'b1 : dd[i]);
      end
   end
   assign dq[0] = (fault[0] == 2) ? 1'b0 : ((fault[0] == 3) ? ~ffq[0] : ffq[0]);
   assign dq[1] = (fault[1] == 2) ? 1'b0 : ((fault[1] == 3) ? ~ffq[1] : ffq[1]);

   function automatic int errv(input int j);
      return (j == 0) ? int'(err0) : int'(err1);
   endfunction

   task automatic check(input string name, input int inst, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, expv);
   endtask

   // Monitor: pops the scoreboard whenever a DUT presents a vector, a result or a due snapshot.
   always @(negedge clk) begin
      vec_t  v;
      res_t  r;
      snap_t s;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n[i]) begin
            vec_q[i].delete();
            res_q[i].delete();
            busy_len[i] = 0;
            wd[i] = 0;
         end else begin
            if (busy[i]) begin
               busy_len[i]++;
               if (vec_q[i].size() == 0) begin
                  check("vec_pending", i, vec_q[i].size(), 1);
               end else begin
                  v = vec_q[i].pop_front();
                  check("vector", i, int'({dd[i], dsn[i], drn[i]}), int'({v.d, v.sn, v.rn}));
               end
            end
            if (done[i] && !done_prev[i]) begin
               if (res_q[i].size() == 0) begin
                  check("res_pending", i, res_q[i].size(), 1);
               end else begin
                  r = res_q[i].pop_front();
                  check("err_count", i, errv(i), r.err);
                  check("pass", i, int'(pass[i]), int'(r.pass));
                  check("busy_len", i, busy_len[i], r.blen);
               end
               busy_len[i] = 0;
               wd[i] = 0;
            end else if (res_q[i].size() != 0) begin
               wd[i]++;
               if (wd[i] > WD_MAX) begin
                  check("done_timeout", i, int'(done[i]), 1);
                  r = res_q[i].pop_front();
                  wd[i] = 0;
               end
            end
         end
         done_prev[i] = done[i];
      end
      while (snap_q.size() != 0 && snap_q[0].at <= cyc) begin
         s = snap_q.pop_front();
         check("snap_busy", s.inst, int'(busy[s.inst]), int'(s.busy));
         check("snap_done", s.inst, int'(done[s.inst]), int'(s.done));
         check("snap_pass", s.inst, int'(pass[s.inst]), int'(s.pass));
         check("snap_err", s.inst, errv(s.inst), s.err);
         check("snap_reset_n", s.inst, int'(drn[s.inst]), int'(s.rn));
      end
      cyc++;
   end

   // Reference model: the vector list and final result of one complete test.
   task automatic push_model(input int i, input int f);
      int   p, r, n, l, fb, errs, maxe;
      bit   ideal, act;
      vec_t v;
      res_t res;
      p    = (i == 0) ? P0 : P1;
      r    = (i == 0) ? R0 : R1;
      l    = (i == 0) ? int'(SEED0) : int'(SEED1);
      maxe = (i == 0) ? 255 : 3;
      if (l == 0) l = 1;
      n    = 2 * p + r;
      errs = 0;
      for (int k = 0; k < n; k++) begin
         v.d  = l[0];
         v.sn = (k >= 2 * p);
         v.rn = (k >= p);
         ideal = !v.rn ? 1'b0 : (!v.sn ? 1'b1 : v.d);
         case (f)
            1:       act = !v.sn ? 1'b1 : (!v.rn ? 1'b0 : v.d);
            2:       act = 1'b0;
            3:       act = !ideal;
            default: act = ideal;
         endcase
         if (act != ideal && errs < maxe) errs++;
         vec_q[i].push_back(v);
         fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
         l  = ((l << 1) | fb) & 255;
      end
      v.d = 1'b0; v.sn = 1'b1; v.rn = 1'b0;
      vec_q[i].push_back(v);
      res.err  = errs;
      res.pass = (errs == 0);
      res.blen = n + 1;
      res_q[i].push_back(res);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_snap(input int at, input int i, input bit b, input bit dn,
                            input bit ps, input int e, input bit rn);
      snap_t s;
      s.at = at; s.inst = i; s.busy = b; s.done = dn; s.pass = ps; s.err = e; s.rn = rn;
      snap_q.push_back(s);
   endtask

   // Bounded wait; an expired bound is reported by the monitor's watchdog.
   task automatic wait_done(input int i);
      int c;
      c = 0;
      while (!done[i] && c < 200) begin
         tick();
         c++;
      end
   endtask

   task automatic run(input int i, input int f, input int gap);
      fault[i] = f;
      push_model(i, f);
      repeat (gap) tick();
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
      wait_done(i);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0;
         start[i] = 1'b0;
         fault[i] = 0;
      end
      repeat (3) tick();
      push_snap(cyc, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      push_snap(cyc, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      // Directed scenarios on the default-parameter instance.
      run(0, 0, 1);
      run(0, 1, 2);
      run(0, 2, 0);
      run(0, 3, 3);

      // Zero seed and 2-bit saturating counter.
      run(1, 0, 1);
      run(1, 3, 0);
      run(1, 2, 2);

      // Reset in the middle of RUN, then an identical rerun.
      fault[0] = 2;
      push_model(0, 2);
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      repeat (14) tick();
      rst_n[0] = 1'b0;
      tick();
      push_snap(cyc, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      rst_n[0] = 1'b1;
      tick();
      run(0, 0, 1);

      // Start held high: no restart while busy, immediate restart from DONE.
      fault[0] = 2;
      push_model(0, 2);
      push_model(0, 2);
      start[0] = 1'b1;
      tick();
      wait_done(0);
      push_snap(cyc + 1, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      repeat (10) tick();
      start[0] = 1'b0;
      wait_done(0);
      tick();

      // Randomised fault mix and start spacing on both instances.
      for (int k = 0; k < 4; k++) run(0, $urandom_range(0, 3), $urandom_range(0, 4));
      for (int k = 0; k < 4; k++) run(1, $urandom_range(0, 3), $urandom_range(0, 4));

      repeat (5) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
